maquina_maluca: RTL and testbench

Sequencer FSM for a coffee-machine control flow. A start pulse launches a fixed brewing sequence, with one water-check loop that refills the reservoir when empty. The block exposes its current state code and a water-present flag to the surrounding control/status logic. It is standalone, with no datapath.

---
 rtl/maquina_maluca_pkg.sv | 19 +
 rtl/maquina_maluca.sv | 63 ++++++
 tb/tb_maquina_maluca.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/maquina_maluca_pkg.sv
// Shared state encoding for the coffee-machine sequencer.
// Status decoders and benches use the same codes.
package maquina_maluca_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9
    } state_t;

endpackage

// File: rtl/maquina_maluca.sv
// Coffee-machine brewing sequencer: a fixed step sequence with one refill loop.
// Moore outputs only; state code and reservoir flag come straight from flops.
module maquina_maluca
    import maquina_maluca_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [STATE_W-1:0] state,
    output logic               agua_enchida
);

    // Power-up values match the reset values so state reads IDLE before any edge.
    state_t state_q = IDLE;
    state_t state_d;
    logic   agua_q  = 1'b0;
    logic   agua_d;

    // Next-state and flag update
    always_comb begin
        state_d = state_q;
        agua_d  = agua_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LIGAR_MAQUINA;
            end
            LIGAR_MAQUINA:  state_d = VERIFICAR_AGUA;
            VERIFICAR_AGUA: begin
                if (agua_q) state_d = MOER_CAFE;
                else        state_d = ENCHER_RESERVATORIO;
            end
            ENCHER_RESERVATORIO: begin
                state_d = VERIFICAR_AGUA;
                agua_d  = 1'b1;
            end
            MOER_CAFE:         state_d = COLOCAR_NO_FILTRO;
            COLOCAR_NO_FILTRO: state_d = PASSAR_AGITADOR;
            PASSAR_AGITADOR:   state_d = TAMPEAR;
            TAMPEAR:           state_d = REALIZAR_EXTRACAO;
            REALIZAR_EXTRACAO: begin
                // Water is consumed by the extraction, so the next cycle refills.
                state_d = IDLE;
                agua_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and flag registers; the active-high reset overrides any transition
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            agua_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            agua_q  <= agua_d;
        end
    end

    assign state        = STATE_W'(state_q);
    assign agua_enchida = agua_q;

endmodule

// File: tb/tb_maquina_maluca.sv
// Directed bench for maquina_maluca: each stimulus step queues the expected
// post-edge state/flag, and an independent monitor checks them after every edge.
module tb_maquina_maluca;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] state;
    logic       agua_enchida;

    typedef struct packed {
        logic [3:0] st;
        logic       fl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    maquina_maluca dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .state        (state),
        .agua_enchida (agua_enchida)
    );

    always #5 clk = ~clk;

    // Monitor: every edge presents a new output; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state t=%0t got=%0d want=%0d", $time, state, e.st);
                end
                total++;
                if (agua_enchida !== e.fl) begin
                    bad++;
                    $display("FAIL agua_enchida t=%0t got=%0b want=%0b", $time, agua_enchida, e.fl);
                end
            end
        end
    end

    // Drive inputs for one edge and queue the values expected right after it
    task automatic step(input logic r, input logic s, input logic [3:0] st, input logic fl);
        rst_n = r;
        start = s;
        exp_q.push_back('{st: st, fl: fl});
        @(posedge clk);
        #1;
    endtask

    // Nine edges after LIGAR with an empty reservoir, start held at s
    task automatic rest_of_cycle(input logic s);
        step(1'b0, s, 4'd3, 1'b0);
        step(1'b0, s, 4'd4, 1'b0);
        step(1'b0, s, 4'd3, 1'b1);
        step(1'b0, s, 4'd5, 1'b1);
        step(1'b0, s, 4'd6, 1'b1);
        step(1'b0, s, 4'd7, 1'b1);
        step(1'b0, s, 4'd8, 1'b1);
        step(1'b0, s, 4'd9, 1'b1);
        step(1'b0, s, 4'd1, 1'b0);
    endtask

    initial begin
        // Power-up value before the first edge
        #1;
        total++;
        if (state !== 4'd1 || agua_enchida !== 1'b0) begin
            bad++;
            $display("FAIL powerup got=%0d/%0b want=1/0", state, agua_enchida);
        end

        // Reset with start high, then idle with start low
        step(1'b1, 1'b1, 4'd1, 1'b0);
        step(1'b1, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd1, 1'b0);

        // Full cycle from a single start pulse
        step(1'b0, 1'b1, 4'd2, 1'b0);
        rest_of_cycle(1'b0);

        // Back-to-back with start held: relaunch must refill again
        step(1'b0, 1'b1, 4'd2, 1'b0);
        rest_of_cycle(1'b1);
        step(1'b0, 1'b1, 4'd2, 1'b0);

        // Start toggled during MOER..EXTRACAO has no effect
        step(1'b0, 1'b0, 4'd3, 1'b0);
        step(1'b0, 1'b0, 4'd4, 1'b0);
        step(1'b0, 1'b0, 4'd3, 1'b1);
        step(1'b0, 1'b1, 4'd5, 1'b1);
        step(1'b0, 1'b0, 4'd6, 1'b1);
        step(1'b0, 1'b1, 4'd7, 1'b1);
        step(1'b0, 1'b0, 4'd8, 1'b1);
        step(1'b0, 1'b1, 4'd9, 1'b1);
        step(1'b0, 1'b0, 4'd1, 1'b0);
        step(1'b0, 1'b0, 4'd1, 1'b0);

        // Reset while in COLOCAR_NO_FILTRO, then a normal launch
        step(1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 4'd3, 1'b0);
        step(1'b0, 1'b0, 4'd4, 1'b0);
        step(1'b0, 1'b0, 4'd3, 1'b1);
        step(1'b0, 1'b0, 4'd5, 1'b1);
        step(1'b0, 1'b0, 4'd6, 1'b1);
        step(1'b1, 1'b0, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd2, 1'b0);
        rest_of_cycle(1'b0);

        // Reset inside the fill loop; the following cycle still refills first
        step(1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 4'd3, 1'b0);
        step(1'b0, 1'b0, 4'd4, 1'b0);
        step(1'b1, 1'b0, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd2, 1'b0);
        rest_of_cycle(1'b0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
